// File: rtl/reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// reservation_station_pkg
// Shared types and constants for the integer reservation station.
//   issue_rs_struct_o : one instruction from the issue stage (values or tags)
//   cdb_o             : one common-data-bus broadcast
//   rs_entry_t        : payload held in each reservation-station slot
//   ALU_OP_*          : integer ALU opcode encodings
// -----------------------------------------------------------------------------
package reservation_station_pkg;

    localparam int RS_DEPTH = 4;
    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 5;
    localparam int RS_OP_W  = 4;

    localparam logic [RS_OP_W-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [RS_OP_W-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [RS_OP_W-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [RS_OP_W-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [RS_OP_W-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [RS_OP_W-1:0] ALU_OP_SLL  = 4'd5;
    localparam logic [RS_OP_W-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [RS_OP_W-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [RS_OP_W-1:0] ALU_OP_SLT  = 4'd8;
    localparam logic [RS_OP_W-1:0] ALU_OP_SLTU = 4'd9;

    typedef struct packed {
        logic                valid;
        logic [RS_OP_W-1:0]  op;
        logic [RS_TAG_W-1:0] rob_tag;
        logic [RS_XLEN-1:0]  rs1_value;
        logic [RS_XLEN-1:0]  rs2_value;
        logic                rs1_rdy;
        logic                rs2_rdy;
        logic [RS_TAG_W-1:0] rs1_q;
        logic [RS_TAG_W-1:0] rs2_q;
    } issue_rs_struct_o;

    typedef struct packed {
        logic                valid;
        logic [RS_TAG_W-1:0] tag;
        logic [RS_XLEN-1:0]  value;
    } cdb_o;

    // Slot payload. Occupancy is implied by position (< count), so no valid bit.
    typedef struct packed {
        logic [RS_OP_W-1:0]  op;
        logic [RS_TAG_W-1:0] rob_tag;
        logic [RS_XLEN-1:0]  rs1_value;
        logic [RS_XLEN-1:0]  rs2_value;
        logic                rs1_rdy;
        logic                rs2_rdy;
        logic [RS_TAG_W-1:0] rs1_q;
        logic [RS_TAG_W-1:0] rs2_q;
    } rs_entry_t;

endpackage

// File: rtl/rs_operand_wakeup.sv
// -----------------------------------------------------------------------------
// rs_operand_wakeup
// Next-state of one source operand under a CDB snoop. A waiting operand whose
// producer tag matches a valid broadcast captures the value and becomes ready;
// an operand that is already ready is left untouched.
//   rdy, q, value        : current operand state
//   cdb_i                : common data bus
//   rdy_next, value_next : operand state after this cycle's broadcast
// -----------------------------------------------------------------------------
module rs_operand_wakeup
    import reservation_station_pkg::*;
(
    input  logic               rdy,
    input  logic [RS_TAG_W-1:0] q,
    input  logic [RS_XLEN-1:0]  value,
    input  cdb_o               cdb_i,
    output logic               rdy_next,
    output logic [RS_XLEN-1:0]  value_next
);

    logic hit;

    assign hit        = !rdy && cdb_i.valid && (cdb_i.tag == q);
    assign rdy_next   = rdy | hit;
    assign value_next = hit ? cdb_i.value : value;

endmodule

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
// Collapsing-queue integer reservation station. Slot 0 is the oldest entry and
// occupied slots are contiguous from 0. Each cycle it can accept one issue,
// wake operands from the CDB, and dispatch the oldest fully-ready entry.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush_i           : squash every entry (wins over all other activity)
//   rs_i              : instruction from the issue stage
//   cdb_i             : result broadcast used for operand wakeup
//   rs_full_o         : all DEPTH slots occupied (registered-state decode)
//   alu_valid_o/alu_ready_i : dispatch handshake with the integer ALU
//   alu_op_o, alu_a_o, alu_b_o, alu_tag_o : offered instruction, 0 when idle
// -----------------------------------------------------------------------------
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int XLEN  = RS_XLEN,
    parameter int TAG_W = RS_TAG_W,
    parameter int OP_W  = RS_OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  issue_rs_struct_o rs_i,
    input  cdb_o             cdb_i,
    output logic             rs_full_o,
    output logic             alu_valid_o,
    input  logic             alu_ready_i,
    output logic [OP_W-1:0]  alu_op_o,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    output logic [TAG_W-1:0] alu_tag_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        slot_q [DEPTH];
    rs_entry_t        slot_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_after;

    // Index DEPTH is the incoming issue entry; it is snooped exactly like a slot
    // so an operand broadcast in its issue cycle is not missed.
    rs_entry_t        cand  [DEPTH+1];
    rs_entry_t        woken [DEPTH+1];
    logic [DEPTH:0]   rs1_rdy_w;
    logic [DEPTH:0]   rs2_rdy_w;
    logic [XLEN-1:0]  rs1_val_w [DEPTH+1];
    logic [XLEN-1:0]  rs2_val_w [DEPTH+1];

    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             fire;
    logic             alloc;

    // ---------------------------------------------------------------- wakeup
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot_cand
        assign cand[k] = slot_q[k];
    end

    assign cand[DEPTH] = '{
        op:        rs_i.op,
        rob_tag:   rs_i.rob_tag,
        rs1_value: rs_i.rs1_value,
        rs2_value: rs_i.rs2_value,
        rs1_rdy:   rs_i.rs1_rdy,
        rs2_rdy:   rs_i.rs2_rdy,
        rs1_q:     rs_i.rs1_q,
        rs2_q:     rs_i.rs2_q
    };

    for (genvar k = 0; k <= DEPTH; k++) begin : g_wakeup
        rs_operand_wakeup u_rs1 (
            .rdy        (cand[k].rs1_rdy),
            .q          (cand[k].rs1_q),
            .value      (cand[k].rs1_value),
            .cdb_i      (cdb_i),
            .rdy_next   (rs1_rdy_w[k]),
            .value_next (rs1_val_w[k])
        );
        rs_operand_wakeup u_rs2 (
            .rdy        (cand[k].rs2_rdy),
            .q          (cand[k].rs2_q),
            .value      (cand[k].rs2_value),
            .cdb_i      (cdb_i),
            .rdy_next   (rs2_rdy_w[k]),
            .value_next (rs2_val_w[k])
        );

        assign woken[k] = '{
            op:        cand[k].op,
            rob_tag:   cand[k].rob_tag,
            rs1_value: rs1_val_w[k],
            rs2_value: rs2_val_w[k],
            rs1_rdy:   rs1_rdy_w[k],
            rs2_rdy:   rs2_rdy_w[k],
            rs1_q:     cand[k].rs1_q,
            rs2_q:     cand[k].rs2_q
        };
    end

    // ---------------------------------------------------------------- select
    // Scan from the youngest slot down so the last hit is the oldest ready one.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path
        // leaves it unassigned and no latch is inferred.
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count_q) && slot_q[i].rs1_rdy && slot_q[i].rs2_rdy) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_full_o   = (count_q == CNT_W'(DEPTH));
    assign fire        = sel_valid && alu_ready_i;
    assign alloc       = rs_i.valid && !rs_full_o;
    assign count_after = count_q - CNT_W'(fire);

    always_comb begin
        alu_valid_o = sel_valid;
        alu_op_o    = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_tag_o   = '0;
        if (sel_valid) begin
            alu_op_o  = slot_q[sel_idx].op;
            alu_a_o   = slot_q[sel_idx].rs1_value;
            alu_b_o   = slot_q[sel_idx].rs2_value;
            alu_tag_o = slot_q[sel_idx].rob_tag;
        end
    end

    // ------------------------------------------------------- collapse / alloc
    // On dispatch, every slot at or above the selected one takes its younger
    // neighbour's woken state; the top slot takes index DEPTH, which is either
    // beyond count or immediately overwritten by the allocation below.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (fire && (CNT_W'(i) >= CNT_W'(sel_idx))) begin
                slot_d[i] = woken[i+1];
            end else begin
                slot_d[i] = woken[i];
            end
            if (alloc && (CNT_W'(i) == count_after)) begin
                slot_d[i] = woken[DEPTH];
            end
        end

        count_d = count_after + CNT_W'(alloc);
        if (flush_i) begin
            count_d = '0;
        end
    end

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: slot payload is deliberately not reset; count_q alone defines which
    // slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station
// Directed, table-driven bench for reservation_station. Each table row holds
// the inputs driven for one cycle and the outputs expected during that cycle
// (outputs depend only on registered state). Reset is exercised by hand.
// -----------------------------------------------------------------------------
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    issue_rs_struct_o rs_i;
    cdb_o             cdb_i;
    logic             rs_full_o;
    logic             alu_valid_o;
    logic             alu_ready_i;
    logic [3:0]       alu_op_o;
    logic [31:0]      alu_a_o;
    logic [31:0]      alu_b_o;
    logic [4:0]       alu_tag_o;

    reservation_station dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .rs_i        (rs_i),
        .cdb_i       (cdb_i),
        .rs_full_o   (rs_full_o),
        .alu_valid_o (alu_valid_o),
        .alu_ready_i (alu_ready_i),
        .alu_op_o    (alu_op_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_tag_o   (alu_tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string            name;
        issue_rs_struct_o iss;
        cdb_o             cdb;
        logic             ardy;
        logic             flush;
        logic             e_full;
        int               e_cnt;
        logic             e_val;
        logic [3:0]       e_op;
        logic [31:0]      e_a;
        logic [31:0]      e_b;
        logic [4:0]       e_tag;
    } vec_t;

    vec_t vecs[$];

    function automatic issue_rs_struct_o iss(input logic [3:0] op, input logic [4:0] tag,
                                             input logic [31:0] a, input logic r1, input logic [4:0] q1,
                                             input logic [31:0] b, input logic r2, input logic [4:0] q2);
        issue_rs_struct_o s;
        s.valid = 1'b1;  s.op = op;        s.rob_tag = tag;
        s.rs1_value = a; s.rs1_rdy = r1;   s.rs1_q = q1;
        s.rs2_value = b; s.rs2_rdy = r2;   s.rs2_q = q2;
        return s;
    endfunction

    function automatic cdb_o cdb(input logic [4:0] tag, input logic [31:0] value);
        cdb_o c;
        c.valid = 1'b1; c.tag = tag; c.value = value;
        return c;
    endfunction

    task automatic add(input string n, input issue_rs_struct_o i, input cdb_o c,
                       input logic ardy, input logic fl, input logic e_full, input int e_cnt,
                       input logic e_val, input logic [3:0] e_op, input logic [31:0] e_a,
                       input logic [31:0] e_b, input logic [4:0] e_tag);
        vec_t v;
        v.name = n; v.iss = i; v.cdb = c; v.ardy = ardy; v.flush = fl;
        v.e_full = e_full; v.e_cnt = e_cnt; v.e_val = e_val; v.e_op = e_op;
        v.e_a = e_a; v.e_b = e_b; v.e_tag = e_tag;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string n, input logic e_full, input int e_cnt,
                                 input logic e_val, input logic [3:0] e_op, input logic [31:0] e_a,
                                 input logic [31:0] e_b, input logic [4:0] e_tag);
        check({n, ".full"},  64'(rs_full_o),    64'(e_full));
        check({n, ".count"}, 64'(dut.count_q),  64'(e_cnt));
        check({n, ".valid"}, 64'(alu_valid_o),  64'(e_val));
        check({n, ".op"},    64'(alu_op_o),     64'(e_op));
        check({n, ".a"},     64'(alu_a_o),      64'(e_a));
        check({n, ".b"},     64'(alu_b_o),      64'(e_b));
        check({n, ".tag"},   64'(alu_tag_o),    64'(e_tag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        issue_rs_struct_o ni;
        cdb_o             nc;
        ni = '0;
        nc = '0;

        // name         issue                                       cdb               rdy fl  full cnt val op           a       b      tag
        add("rst_idle", ni,                                          nc,               0, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        add("t1_issue", iss(ALU_OP_ADD, 3, 5, 1, 0, 7, 1, 0),        nc,               1, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        add("t1_offer", ni,                                          nc,               1, 0,  0, 1, 1, ALU_OP_ADD,  5,      7,     3);
        add("t1_empty", ni,                                          nc,               0, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        // rs2 is ready with a q that matches the later broadcast: must not be overwritten.
        add("t2_issue", iss(ALU_OP_SUB, 6, 0, 0, 9, 2, 1, 9),        nc,               1, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        add("t2_wait",  ni,                                          nc,               1, 0,  0, 1, 0, 4'd0,        0,      0,     0);
        add("t2_cdb",   ni,                                          cdb(9, 32'h10),   1, 0,  0, 1, 0, 4'd0,        0,      0,     0);
        add("t2_offer", ni,                                          nc,               1, 0,  0, 1, 1, ALU_OP_SUB,  32'h10, 2,     6);
        add("t3_issue", iss(ALU_OP_AND, 7, 1, 1, 0, 0, 0, 4),        cdb(4, 32'hAA),   0, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        add("t3_hold",  ni,                                          nc,               0, 0,  0, 1, 1, ALU_OP_AND,  1,      32'hAA,7);
        add("t3_offer", ni,                                          nc,               1, 0,  0, 1, 1, ALU_OP_AND,  1,      32'hAA,7);
        add("q_fill1",  iss(ALU_OP_OR,  1, 0, 0, 11, 32'h11, 1, 0),  nc,               0, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        add("q_fill2",  iss(ALU_OP_XOR, 2, 32'h21, 1, 0, 32'h22, 1, 0), nc,            0, 0,  0, 1, 0, 4'd0,        0,      0,     0);
        add("q_fill3",  iss(ALU_OP_SLL, 3, 32'h31, 1, 0, 0, 0, 13),  nc,               0, 0,  0, 2, 1, ALU_OP_XOR,  32'h21, 32'h22,2);
        add("q_fill4",  iss(ALU_OP_SRL, 4, 32'h41, 1, 0, 32'h42, 1, 0), nc,            0, 0,  0, 3, 1, ALU_OP_XOR,  32'h21, 32'h22,2);
        add("q_disp2",  ni,                                          nc,               1, 0,  1, 4, 1, ALU_OP_XOR,  32'h21, 32'h22,2);
        add("q_disp4",  ni,                                          nc,               1, 0,  0, 3, 1, ALU_OP_SRL,  32'h41, 32'h42,4);
        add("q_wake1",  ni,                                          cdb(11, 32'h111), 0, 0,  0, 2, 0, 4'd0,        0,      0,     0);
        add("f_fill5",  iss(ALU_OP_SRA, 5, 32'h51, 1, 0, 32'h52, 1, 0), nc,            0, 0,  0, 2, 1, ALU_OP_OR,   32'h111,32'h11,1);
        add("f_fill6",  iss(ALU_OP_SLT, 8, 0, 0, 20, 32'h62, 1, 0),  nc,               0, 0,  0, 3, 1, ALU_OP_OR,   32'h111,32'h11,1);
        add("f_drop7",  iss(ALU_OP_SLTU,10, 32'h71, 1, 0, 32'h72, 1, 0), nc,           1, 0,  1, 4, 1, ALU_OP_OR,   32'h111,32'h11,1);
        add("f_after",  ni,                                          nc,               0, 0,  0, 3, 1, ALU_OP_SRA,  32'h51, 32'h52,5);
        add("fl_flush", iss(ALU_OP_ADD, 12, 1, 1, 0, 2, 1, 0),       nc,               1, 1,  0, 3, 1, ALU_OP_SRA,  32'h51, 32'h52,5);
        add("fl_empty", ni,                                          nc,               0, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        add("fl_reuse", iss(ALU_OP_ADD, 14, 32'hE1, 1, 0, 32'hE2, 1, 0), nc,           0, 0,  0, 0, 0, 4'd0,        0,      0,     0);
        add("fl_offer", ni,                                          nc,               0, 0,  0, 1, 1, ALU_OP_ADD,  32'hE1, 32'hE2,14);

        rst_n       = 1'b0;
        flush_i     = 1'b0;
        rs_i        = '0;
        cdb_i       = '0;
        alu_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            rs_i        = vecs[n].iss;
            cdb_i       = vecs[n].cdb;
            alu_ready_i = vecs[n].ardy;
            flush_i     = vecs[n].flush;
            #1;
            if (rs_i.valid && rs_full_o) begin
                viol++;
                $display("note: issue of tag %0d attempted while full (dropped)", rs_i.rob_tag);
            end
            check_outputs(vecs[n].name, vecs[n].e_full, vecs[n].e_cnt, vecs[n].e_val,
                          vecs[n].e_op, vecs[n].e_a, vecs[n].e_b, vecs[n].e_tag);
        end
        check("protocol_violations", 64'(viol), 64'd1);

        // Fill to full behind the waiting tag-14 entry, then reset mid-cycle.
        for (int t = 15; t < 18; t++) begin
            @(negedge clk);
            rs_i        = iss(ALU_OP_XOR, 5'(t), 32'(t), 1, 0, 32'(t), 1, 0);
            cdb_i       = '0;
            alu_ready_i = 1'b0;
            flush_i     = 1'b0;
        end
        @(negedge clk);
        rs_i = '0;
        #1;
        check_outputs("pre_reset", 1'b1, 4, 1'b1, ALU_OP_ADD, 32'hE1, 32'hE2, 5'd14);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, 0, 1'b0, 4'd0, 0, 0, 5'd0);

        @(negedge clk);
        rst_n = 1'b1;
        rs_i  = iss(ALU_OP_SLTU, 21, 32'h5, 1, 0, 32'h6, 1, 0);
        #1;
        check_outputs("post_reset_issue", 1'b0, 0, 1'b0, 4'd0, 0, 0, 5'd0);
        @(negedge clk);
        rs_i        = '0;
        alu_ready_i = 1'b1;
        #1;
        check_outputs("post_reset_offer", 1'b0, 1, 1'b1, ALU_OP_SLTU, 32'h5, 32'h6, 5'd21);
        @(negedge clk);
        alu_ready_i = 1'b0;
        #1;
        check_outputs("post_reset_empty", 1'b0, 0, 1'b0, 4'd0, 0, 0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Integer reservation station for the Tomasulo back end. It accepts one instruction per cycle from the issue stage, holding operand values or producer ROB tags. It snoops the common data bus (CDB) to wake waiting operands and dispatches the oldest fully-ready entry to the integer ALU over a valid/ready handshake. It asserts `rs_full_o` back to the issue stage, which consumes it as `rs_full_i`.

## Interface
- `DEPTH`, 4 — entry count, power of two, ≥2
- `XLEN`, 32 — operand/result width
- `TAG_W`, 5 — ROB tag width
- `OP_W`, 4 — ALU opcode width
- `clk  in  1` — single clock; all state updates on rising edge
- `rst_n  in  1` — reset, asynchronous, active-low
- `flush_i  in  1` — synchronous squash of all entries (mispredict)
- `rs_i  in  issue_rs_struct_o` — fields: valid, op[OP_W], rob_tag[TAG_W], rs1_value/rs2_value[XLEN], rs1_rdy/rs2_rdy, rs1_q/rs2_q[TAG_W]
- `cdb_i  in  cdb_o` — fields: valid, tag[TAG_W], value[XLEN]
- `rs_full_o  out  1` — all DEPTH entries occupied
- `alu_valid_o  out  1` — dispatch offer valid
- `alu_ready_i  in  1` — ALU accepts the offer
- `alu_op_o  out  OP_W`, `alu_a_o  out  XLEN`, `alu_b_o  out  XLEN`, `alu_tag_o  out  TAG_W` — dispatched instruction

## Operation
- Storage is a collapsing queue. Slot 0 is always the oldest, and occupied slots are contiguous from 0. `count` ranges 0..DEPTH.
- Allocate: when `rs_i.valid && !rs_full_o`, write the entry into slot `count` (after collapse if a dispatch fires the same cycle, i.e. slot `count-1`).
- `rs_i.valid` while `rs_full_o` is a protocol violation. The entry is dropped and the bench flags it. Fullness uses registered `count`, so a same-cycle dispatch does not free space for that cycle's issue.
- Wakeup: for every occupied operand with rdy=0, if `cdb_i.valid && cdb_i.tag == q`, then value←`cdb_i.value`, rdy←1.
  - The incoming `rs_i` operand is compared against the same-cycle CDB too.
  - An already-ready operand is never overwritten.
  - Tag 0 has no special meaning; the issue stage marks x0 operands ready.
- Select: `alu_valid_o` = any occupied entry with rs1_rdy && rs2_rdy. The offer is the lowest-index such entry, driven combinationally from registered state. `alu_a_o`=rs1_value, `alu_b_o`=rs2_value.
- The offer is not required to be stable while `alu_ready_i`=0. An older entry waking may replace it. The ALU samples only on handshake.
- Dispatch: on `alu_valid_o && alu_ready_i`, remove the selected slot and shift all younger slots down one. Wakeups apply to shifted entries in the same cycle.
- Flush: clears `count` to 0. It has priority over allocate, wakeup and dispatch in the same cycle. Outputs go to 0 the following cycle.
- Outputs while `alu_valid_o`=0 are driven to 0.

## Timing
- Reset (async assert, sync-deasserted by top) values: `count`=0, all entries invalid, `rs_full_o`=0, `alu_valid_o`=0, `alu_op_o`/`alu_a_o`/`alu_b_o`/`alu_tag_o`=0.
- Issue→dispatch latency: an instruction issued in cycle N with both operands ready is offered in cycle N+1.
- CDB→dispatch latency: an operand broadcast in cycle N makes its entry offerable in N+1. There is no same-cycle CDB-to-ALU bypass.
- `rs_full_o` is a registered-state decode (`count==DEPTH`), valid from cycle start.
- Throughput: one allocate and one dispatch per cycle, both allowed simultaneously.

## Structure
- `issue_rs_struct_o` and `cdb_o` typedefs belong in `struct.v`. ALU op encodings (`ALU_OP_*`) belong in `constants.vh`.
- Sub-module `rs_operand_wakeup` (one per operand per slot): inputs rdy, q, value, CDB; outputs next rdy/value. Instantiated 2×(DEPTH+1) times, including the incoming issue slot.
- The top module holds the slot array, count, priority select and collapse mux.

## Test plan
- Ready issue: issue op=ADD, a=5, b=7, tag=3, both rdy, `alu_ready_i`=1 in cycle 0 → cycle 1 offers a=5 b=7 tag=3 and handshakes; count returns to 0.
- Wakeup: issue with rs1_q=9 not ready, rs2=2 ready; CDB tag=9 value=0x10 in cycle 3 → offered in cycle 4 with a=0x10.
- Same-cycle capture: issue with rs2_q=4 while CDB tag=4 value=0xAA in the same cycle → entry stored ready and offered the next cycle with b=0xAA.
- Oldest-first and collapse: fill 4 entries (tags 1..4) with only tags 2 and 4 ready, `alu_ready_i`=1 → tag 2 then tag 4 dispatch; tags 1 and 3 end in slots 0 and 1; `rs_full_o` falls after the first dispatch.
- Full boundary: with 4 entries, `rs_full_o`=1; simultaneous dispatch and issue attempt → issue dropped and flagged, count=3.
- Flush and reset: flush with 3 entries plus a same-cycle issue and handshake → next cycle count=0 and all outputs 0; assert `rst_n`=0 mid-operation → outputs 0 immediately, without waiting for a clock edge.
